// File: rtl/lenet_layer_scheduler.sv
// Per-layer channel sequencer: launches convolution for each output channel,
// optionally gates the pooling engine after a settle gap, and flags layer end.
module lenet_layer_scheduler #(
  parameter int NUM_CH = 6,
  parameter int CH_W   = 3,
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            pool_en,
  input  logic            conv_done,
  input  logic            pool_done,
  output logic            conv_start,
  output logic [1:0]      cal_wait,
  output logic [CH_W-1:0] ch_idx,
  output logic            busy,
  output logic            layer_done
);

  // state        | meaning
  // IDLE         | waiting for start
  // CONV_START   | one-cycle launch pulse for ch_idx
  // CONV_WAIT    | waiting for conv_done
  // SETTLE       | SETTLE idle cycles before pooling
  // POOL_RUN     | pooling enabled, waiting for pool_done
  // POOL_DRAIN   | pooling held, waiting for pool_done to drop
  // NEXT         | advance channel or finish
  // DONE         | layer_done pulse
  typedef enum logic [2:0] {
    ST_IDLE, ST_CONV_START, ST_CONV_WAIT, ST_SETTLE,
    ST_POOL_RUN, ST_POOL_DRAIN, ST_NEXT, ST_DONE
  } state_t;

  localparam logic [3:0]      SETTLE_M1 = 4'(SETTLE - 1);
  localparam logic [CH_W-1:0] LAST_CH   = CH_W'(NUM_CH - 1);

  generate
    if (NUM_CH > (2 ** CH_W) || SETTLE < 1 || SETTLE > 15) begin : g_bad_param
      $error("lenet_layer_scheduler: parameter out of range");
    end
  endgenerate

  state_t          state_q, state_d;
  logic [CH_W-1:0] ch_idx_q, ch_idx_d;
  logic [3:0]      settle_cnt_q, settle_cnt_d;
  logic            pool_en_q, pool_en_d;
  logic            conv_start_q, conv_start_d;
  logic [1:0]      cal_wait_q, cal_wait_d;
  logic            busy_q, busy_d;
  logic            layer_done_q, layer_done_d;

  always_comb begin
    state_d      = state_q;
    ch_idx_d     = ch_idx_q;
    settle_cnt_d = settle_cnt_q;
    pool_en_d    = pool_en_q;
    if (state_q != ST_IDLE && abort) begin
      state_d      = ST_IDLE;
      ch_idx_d     = '0;
      settle_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            pool_en_d = pool_en;
            ch_idx_d  = '0;
            state_d   = ST_CONV_START;
          end
        end
        ST_CONV_START: state_d = ST_CONV_WAIT;
        ST_CONV_WAIT: begin
          if (conv_done) begin
            if (pool_en_q) begin
              state_d      = ST_SETTLE;
              settle_cnt_d = SETTLE_M1;
            end else begin
              state_d = ST_NEXT;
            end
          end
        end
        // loaded with SETTLE-1 so the terminal count lands on the last gap cycle
        ST_SETTLE: begin
          if (settle_cnt_q == 4'd0) state_d = ST_POOL_RUN;
          else settle_cnt_d = settle_cnt_q - 4'd1;
        end
        ST_POOL_RUN:   if (pool_done)  state_d = ST_POOL_DRAIN;
        ST_POOL_DRAIN: if (!pool_done) state_d = ST_NEXT;
        ST_NEXT: begin
          if (ch_idx_q == LAST_CH) begin
            state_d = ST_DONE;
          end else begin
            ch_idx_d = ch_idx_q + CH_W'(1);
            state_d  = ST_CONV_START;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    // outputs follow the next state so they are registered alongside it
    conv_start_d = (state_d == ST_CONV_START);
    cal_wait_d   = (state_d == ST_POOL_RUN) ? 2'b11 : 2'b00;
    busy_d       = (state_d != ST_IDLE);
    layer_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ch_idx_q     <= '0;
      settle_cnt_q <= '0;
      pool_en_q    <= 1'b0;
      conv_start_q <= 1'b0;
      cal_wait_q   <= 2'b00;
      busy_q       <= 1'b0;
      layer_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_idx_q     <= ch_idx_d;
      settle_cnt_q <= settle_cnt_d;
      pool_en_q    <= pool_en_d;
      conv_start_q <= conv_start_d;
      cal_wait_q   <= cal_wait_d;
      busy_q       <= busy_d;
      layer_done_q <= layer_done_d;
    end
  end

  assign conv_start = conv_start_q;
  assign cal_wait   = cal_wait_q;
  assign ch_idx     = ch_idx_q;
  assign busy       = busy_q;
  assign layer_done = layer_done_q;

endmodule
